// File: rtl/lycan_globals.sv
// ============================================================================
// lycan_globals : shared FT601 bus widths and arbiter state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package lycan_globals;

  localparam int FT_DATA_W = 32;
  localparam int FT_BE_W   = 4;

  typedef logic [1:0] ft_arb_state_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RX_TURN  = 2'd1;
  localparam logic [1:0] ST_RX_BURST = 2'd2;
  localparam logic [1:0] ST_TX_BURST = 2'd3;

  localparam logic GRANT_RX = 1'b0;
  localparam logic GRANT_TX = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ft601_arbiter.sv
// ============================================================================
// ft601_arbiter : FT601 245-sync FIFO bus sequencer, RX/TX burst arbitration
// Rev 1.0
// ============================================================================
`default_nettype none

module ft601_arbiter
  import lycan_globals::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire  [FT_DATA_W-1:0] usb_data,
  inout  wire  [FT_BE_W-1:0]   usb_be,
  input  logic                 usb_rx_empty,
  input  logic                 usb_tx_full,
  output logic                 usb_rden_l,
  output logic                 usb_outen_l,
  output logic                 usb_wren_l,
  output logic [FT_DATA_W-1:0] rx_data,
  output logic [FT_BE_W-1:0]   rx_be,
  output logic                 rx_valid,
  input  logic                 rx_afull,
  input  logic [FT_DATA_W-1:0] tx_data,
  input  logic [FT_BE_W-1:0]   tx_be,
  input  logic                 tx_valid,
  output logic                 tx_rd,
  output logic                 busy
);

  localparam int               CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  ft_arb_state_t    state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [FT_DATA_W-1:0] rx_data_q;
  logic [FT_BE_W-1:0]   rx_be_q;
  logic                 rx_valid_q;

  logic rx_req, tx_req, in_rx, in_tx, capture;

  assign rx_req  = ~usb_rx_empty & ~rx_afull;
  assign tx_req  = tx_valid & ~usb_tx_full;
  assign in_rx   = (state_q == ST_RX_TURN) || (state_q == ST_RX_BURST);
  assign in_tx   = (state_q == ST_TX_BURST);
  assign capture = (state_q == ST_RX_BURST) & ~rx_afull & ~usb_rx_empty;

  // Strobes are pure decodes so a reset edge releases everything with the state.
  assign usb_outen_l = ~in_rx;
  assign usb_rden_l  = (state_q == ST_RX_BURST) ? rx_afull : 1'b1;
  assign usb_wren_l  = in_tx ? ~tx_valid : 1'b1;
  assign tx_rd       = in_tx & tx_req;
  assign busy        = (state_q != ST_IDLE);

  assign usb_data = in_tx ? tx_data : {FT_DATA_W{1'bz}};
  assign usb_be   = in_tx ? tx_be   : {FT_BE_W{1'bz}};

  assign rx_data  = rx_data_q;
  assign rx_be    = rx_be_q;
  assign rx_valid = rx_valid_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // On contention the direction that did not go last wins.
        if (rx_req && (!tx_req || last_grant_q == GRANT_TX)) begin
          state_d      = ST_RX_TURN;
          last_grant_d = GRANT_RX;
          burst_cnt_d  = '0;
        end else if (tx_req) begin
          state_d      = ST_TX_BURST;
          last_grant_d = GRANT_TX;
          burst_cnt_d  = '0;
        end
      end
      ST_RX_TURN: state_d = ST_RX_BURST;
      ST_RX_BURST: begin
        burst_cnt_d = burst_cnt_q + CNT_W'(capture);
        if (usb_rx_empty || rx_afull || burst_cnt_d == BURST_LIMIT) begin
          state_d = ST_IDLE;
        end
      end
      ST_TX_BURST: begin
        burst_cnt_d = burst_cnt_q + CNT_W'(tx_rd);
        if (!tx_valid || usb_tx_full || burst_cnt_d == BURST_LIMIT) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_TX;
      burst_cnt_q  <= '0;
      rx_data_q    <= '0;
      rx_be_q      <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      rx_valid_q   <= capture;
      if (capture) begin
        rx_data_q <= usb_data;
        rx_be_q   <= usb_be;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ft601_arbiter.sv
// ============================================================================
// tb_ft601_arbiter : directed checks of ft601_arbiter against an FT601 model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ft601_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst;
  wire  [31:0] usb_data;
  wire  [3:0]  usb_be;
  logic        usb_rx_empty, usb_tx_full;
  logic        usb_rden_l, usb_outen_l, usb_wren_l;
  logic [31:0] rx_data;
  logic [3:0]  rx_be;
  logic        rx_valid, rx_afull;
  logic [31:0] tx_data;
  logic [3:0]  tx_be;
  logic        tx_valid, tx_rd, busy;

  // FT601 host-side FIFO and TX packet FIFO models
  logic [31:0] host_mem [0:255];
  logic [3:0]  host_bem [0:255];
  logic [7:0]  host_rd = 8'd0;
  logic [7:0]  host_wr;
  logic [31:0] txf_mem [0:255];
  logic [3:0]  txf_bem [0:255];
  logic [7:0]  tx_ptr = 8'd0;
  logic [7:0]  tx_len;

  logic [31:0] rx_log [0:255];
  logic [3:0]  rx_be_log [0:255];
  int          rx_n = 0;
  logic [31:0] tx_log [0:255];
  logic [3:0]  tx_be_log [0:255];
  int          tx_n = 0;

  int n_checks = 0;
  int n_pass   = 0;

  assign usb_rx_empty = (host_rd == host_wr);
  assign usb_data     = usb_outen_l ? 32'bz : host_mem[host_rd];
  assign usb_be       = usb_outen_l ? 4'bz  : host_bem[host_rd];
  assign tx_valid     = (tx_ptr != tx_len);
  assign tx_data      = txf_mem[tx_ptr];
  assign tx_be        = txf_bem[tx_ptr];

  ft601_arbiter #(.MAX_BURST(MAXB)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .usb_data     (usb_data),
    .usb_be       (usb_be),
    .usb_rx_empty (usb_rx_empty),
    .usb_tx_full  (usb_tx_full),
    .usb_rden_l   (usb_rden_l),
    .usb_outen_l  (usb_outen_l),
    .usb_wren_l   (usb_wren_l),
    .rx_data      (rx_data),
    .rx_be        (rx_be),
    .rx_valid     (rx_valid),
    .rx_afull     (rx_afull),
    .tx_data      (tx_data),
    .tx_be        (tx_be),
    .tx_valid     (tx_valid),
    .tx_rd        (tx_rd),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!usb_rden_l && !usb_rx_empty) host_rd <= host_rd + 8'd1;
    if (tx_rd) tx_ptr <= tx_ptr + 8'd1;
    if (rx_valid) begin
      rx_log[rx_n]    <= rx_data;
      rx_be_log[rx_n] <= rx_be;
      rx_n            <= rx_n + 1;
    end
    if (!usb_wren_l && !usb_tx_full) begin
      tx_log[tx_n]    <= usb_data;
      tx_be_log[tx_n] <= usb_be;
      tx_n            <= tx_n + 1;
    end
  end

  // I idle, t outen-only (turnaround/stall), R read word, e read strobe on empty,
  // T write accepted, w write strobe refused, x busy with nothing on the bus
  function automatic byte bus_code();
    if (!busy)             return "I";
    if (!usb_outen_l)      return usb_rden_l ? "t" : (usb_rx_empty ? "e" : "R");
    if (tx_rd)             return "T";
    if (!usb_wren_l)       return "w";
    return "x";
  endfunction

  function automatic bit bus_clash();
    return !usb_outen_l && (!usb_wren_l || tx_rd);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++;
    if ({usb_rden_l, usb_outen_l, usb_wren_l} !== 3'b111)
      $display("FAIL reset_strobes got=%b exp=111", {usb_rden_l, usb_outen_l, usb_wren_l});
    else n_pass++;
    n_checks++;
    if ({rx_valid, tx_rd, rx_data, rx_be} !== 38'd0)
      $display("FAIL reset_rx got=%b/%b/%h/%h exp=0/0/0/0", rx_valid, tx_rd, rx_data, rx_be);
    else n_pass++;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_contention();
    string exp = "ItRRRRRRRRITTTTTTTTItRReITTxII";
    int    rb = rx_n, tb = tx_n;
    byte   h0 = host_wr, t0 = tx_len;
    for (int cyc = 0; cyc < exp.len(); cyc++) begin
      if (cyc == 0) begin host_wr = host_wr + 8'd10; tx_len = tx_len + 8'd10; end
      @(negedge clk);
      n_checks++;
      if (bus_code() != exp.getc(cyc))
        $display("FAIL contention_seq cyc=%0d got=%c exp=%c", cyc, bus_code(), exp.getc(cyc));
      else n_pass++;
      n_checks++; if (bus_clash()) $display("FAIL contention_clash cyc=%0d got=1 exp=0", cyc); else n_pass++;
      next_cycle();
    end
    n_checks++;
    if (rx_n - rb != 10 || tx_n - tb != 10)
      $display("FAIL contention_counts got=%0d/%0d exp=10/10", rx_n - rb, tx_n - tb);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (rx_log[rb+k] !== host_mem[8'(h0+k)] || tx_log[tb+k] !== txf_mem[8'(t0+k)] ||
          tx_be_log[tb+k] !== txf_bem[8'(t0+k)])
        $display("FAIL contention_data k=%0d got=%h/%h exp=%h/%h", k, rx_log[rb+k], tx_log[tb+k],
                 host_mem[8'(h0+k)], txf_mem[8'(t0+k)]);
      else n_pass++;
    end
  endtask

  task automatic test_rx_burst();
    string exp = "ItRRRRRRRRII";
    byte   h0 = host_wr;
    for (int cyc = 0; cyc < exp.len(); cyc++) begin
      if (cyc == 0) host_wr = host_wr + 8'd8;
      @(negedge clk);
      n_checks++;
      if (bus_code() != exp.getc(cyc))
        $display("FAIL rx8_seq cyc=%0d got=%c exp=%c", cyc, bus_code(), exp.getc(cyc));
      else n_pass++;
      n_checks++;
      if (rx_valid !== (cyc >= 3 && cyc <= 10))
        $display("FAIL rx8_valid cyc=%0d got=%b exp=%b", cyc, rx_valid, (cyc >= 3 && cyc <= 10));
      else n_pass++;
      if (cyc >= 3 && cyc <= 10) begin
        n_checks++;
        if (rx_data !== host_mem[8'(h0+cyc-3)] || rx_be !== host_bem[8'(h0+cyc-3)])
          $display("FAIL rx8_data cyc=%0d got=%h/%h exp=%h/%h", cyc, rx_data, rx_be,
                   host_mem[8'(h0+cyc-3)], host_bem[8'(h0+cyc-3)]);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_rx_afull();
    string exp = "ItRRRtIIItRRRRReI";
    int    rb = rx_n;
    byte   h0 = host_wr;
    for (int cyc = 0; cyc < exp.len(); cyc++) begin
      if (cyc == 0) host_wr = host_wr + 8'd8;
      if (cyc == 5) rx_afull = 1'b1;
      if (cyc == 8) rx_afull = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus_code() != exp.getc(cyc))
        $display("FAIL afull_seq cyc=%0d got=%c exp=%c", cyc, bus_code(), exp.getc(cyc));
      else n_pass++;
      if (cyc == 8) begin
        n_checks++;
        if (rx_n - rb != 3) $display("FAIL afull_count3 got=%0d exp=3", rx_n - rb); else n_pass++;
      end
      next_cycle();
    end
    next_cycle();
    n_checks++;
    if (rx_n - rb != 8) $display("FAIL afull_count8 got=%0d exp=8", rx_n - rb); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (rx_log[rb+k] !== host_mem[8'(h0+k)])
        $display("FAIL afull_data k=%0d got=%h exp=%h", k, rx_log[rb+k], host_mem[8'(h0+k)]);
      else n_pass++;
    end
  endtask

  task automatic test_tx_full_pulse();
    string exp = "ITTwITTTTxI";
    int    tb = tx_n;
    byte   t0 = tx_len;
    for (int cyc = 0; cyc < exp.len(); cyc++) begin
      if (cyc == 0) tx_len = tx_len + 8'd6;
      if (cyc == 3) usb_tx_full = 1'b1;
      if (cyc == 4) usb_tx_full = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus_code() != exp.getc(cyc))
        $display("FAIL txfull_seq cyc=%0d got=%c exp=%c", cyc, bus_code(), exp.getc(cyc));
      else n_pass++;
      next_cycle();
    end
    n_checks++;
    if (tx_n - tb != 6) $display("FAIL txfull_count got=%0d exp=6", tx_n - tb); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (tx_log[tb+k] !== txf_mem[8'(t0+k)])
        $display("FAIL txfull_data k=%0d got=%h exp=%h", k, tx_log[tb+k], txf_mem[8'(t0+k)]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midburst();
    string exp = "ItRRItRRR";
    int    rb = rx_n, tb = tx_n, guard = 0;
    byte   h0 = host_wr, t0 = tx_len;
    for (int cyc = 0; cyc < exp.len(); cyc++) begin
      if (cyc == 0) host_wr = host_wr + 8'd8;
      if (cyc == 3) rst = 1'b1;
      if (cyc == 4) begin rst = 1'b0; tx_len = tx_len + 8'd4; end
      @(negedge clk);
      n_checks++;
      if (bus_code() != exp.getc(cyc))
        $display("FAIL rstmid_seq cyc=%0d got=%c exp=%c", cyc, bus_code(), exp.getc(cyc));
      else n_pass++;
      if (cyc == 4) begin
        n_checks++;
        if ({usb_rden_l, usb_outen_l, usb_wren_l, busy, rx_valid, tx_rd} !== 6'b111000)
          $display("FAIL rstmid_release got=%b exp=111000",
                   {usb_rden_l, usb_outen_l, usb_wren_l, busy, rx_valid, tx_rd});
        else n_pass++;
      end
      next_cycle();
    end
    while ((busy || !usb_rx_empty || tx_valid) && guard < 80) begin
      @(negedge clk);
      n_checks++; if (bus_clash()) $display("FAIL rstmid_clash got=1 exp=0"); else n_pass++;
      next_cycle();
      guard++;
    end
    n_checks++;
    if (guard >= 80) $display("FAIL rstmid_drain_timeout got=%0d exp=<80", guard); else n_pass++;
    next_cycle();
    next_cycle();
    n_checks++;
    if (rx_n - rb != 7 || tx_n - tb != 4)
      $display("FAIL rstmid_counts got=%0d/%0d exp=7/4", rx_n - rb, tx_n - tb);
    else n_pass++;
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (rx_log[rb+k] !== host_mem[8'(h0 + (k == 0 ? 0 : k + 1))])
        $display("FAIL rstmid_rx k=%0d got=%h exp=%h", k, rx_log[rb+k],
                 host_mem[8'(h0 + (k == 0 ? 0 : k + 1))]);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (tx_log[tb+k] !== txf_mem[8'(t0+k)])
        $display("FAIL rstmid_tx k=%0d got=%h exp=%h", k, tx_log[tb+k], txf_mem[8'(t0+k)]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      host_mem[i] = 32'hA5C0_0000 + 32'(i * 32'h0001_0203);
      host_bem[i] = 4'(i);
      txf_mem[i]  = 32'h3B00_0000 + 32'(i * 32'h0000_0711);
      txf_bem[i]  = ~4'(i);
    end
    host_wr     = 8'd0;
    tx_len      = 8'd0;
    rx_afull    = 1'b0;
    usb_tx_full = 1'b0;
    rst         = 1'b1;
    test_reset();
    test_contention();
    test_rx_burst();
    test_rx_afull();
    test_tx_full_pulse();
    test_reset_midburst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
